// File: rtl/score_display_ctrl_if.sv
// rtl/score_display_ctrl_if.sv - value handshake between game FSM and display controller
// Purpose: carries the binary value offer and its ready/valid handshake.
// Signals:
//   value_valid_i  new value offered (driven by master)
//   value_i[13:0]  unsigned binary value (driven by master)
//   value_ready_o  controller idle and able to accept (driven by slave)
interface score_display_ctrl_if;
  logic        value_valid_i;
  logic [13:0] value_i;
  logic        value_ready_o;

  modport master (output value_valid_i, output value_i, input value_ready_o);
  modport slave  (input value_valid_i, input value_i, output value_ready_o);
endinterface

// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - binary to 4-digit BCD display controller with blanking and blink
// Purpose: sequential double-dabble conversion (one bit per clock), saturation above 9999,
//          leading-zero blanking and whole-display blinking for a 7-seg driver.
// Ports:
//   clk_1k_i            display clock
//   rst_i               asynchronous active-high reset
//   val_if (slave)      value_valid_i / value_i / value_ready_o handshake
//   blank_lz_i          1 = blank leading zeros
//   blink_i             1 = blink whole display
//   digitN_en_o/digitN_o  per-digit enable and BCD value, N=0 (ones) .. 3 (thousands)
//   overflow_o          last accepted value was above 9999
module score_display_ctrl #(
  parameter int BLINK_HALF = 500
) (
  input  logic                 clk_1k_i,
  input  logic                 rst_i,
  score_display_ctrl_if.slave  val_if,
  input  logic                 blank_lz_i,
  input  logic                 blink_i,
  output logic                 digit0_en_o,
  output logic [3:0]           digit0_o,
  output logic                 digit1_en_o,
  output logic [3:0]           digit1_o,
  output logic                 digit2_en_o,
  output logic [3:0]           digit2_o,
  output logic                 digit3_en_o,
  output logic [3:0]           digit3_o,
  output logic                 overflow_o
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic [13:0] r_shift;
  logic [15:0] r_bcd;
  logic [3:0]  r_bit_cnt;
  logic        r_ovf_pend;
  logic [3:0]  r_digit0;
  logic [3:0]  r_digit1;
  logic [3:0]  r_digit2;
  logic [3:0]  r_digit3;
  logic        r_overflow;

  logic [CW-1:0] r_blink_cnt;
  logic          r_blink_phase;

  logic [15:0] w_bcd_adj;
  logic [29:0] w_shifted;
  logic        w_vis;
  logic        w_d3_nz;
  logic        w_d2_nz;
  logic        w_d1_nz;

  // Add-3 correction on every nibble that would reach 10 or more after doubling.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int n = 0; n < 4; n++) begin
      if (r_bcd[n*4 +: 4] >= 4'd5) begin
        w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
      end
    end
  end

  assign w_shifted = {w_bcd_adj, r_shift} << 1;

  // Conversion FSM. Values above 9999 still run the full conversion so the
  // latency is constant; the scratch result is then replaced by 9999.
  always_ff @(posedge clk_1k_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_bit_cnt  <= '0;
      r_ovf_pend <= 1'b0;
      r_digit0   <= '0;
      r_digit1   <= '0;
      r_digit2   <= '0;
      r_digit3   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (val_if.value_valid_i && r_ready) begin
            r_shift    <= val_if.value_i;
            r_bcd      <= '0;
            r_bit_cnt  <= '0;
            r_ovf_pend <= (val_if.value_i > 14'd9999);
            r_ready    <= 1'b0;
            r_state    <= S_CONV;
          end
        end
        S_CONV: begin
          r_bcd     <= w_shifted[29:14];
          r_shift   <= w_shifted[13:0];
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd13) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_ovf_pend) begin
            r_digit0 <= 4'd9;
            r_digit1 <= 4'd9;
            r_digit2 <= 4'd9;
            r_digit3 <= 4'd9;
          end else begin
            r_digit0 <= r_bcd[3:0];
            r_digit1 <= r_bcd[7:4];
            r_digit2 <= r_bcd[11:8];
            r_digit3 <= r_bcd[15:12];
          end
          r_overflow <= r_ovf_pend;
          r_ready    <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Blink timer: held at the visible phase while blinking is off so every
  // blink begins with a full on half-period.
  always_ff @(posedge clk_1k_i or posedge rst_i) begin
    if (rst_i) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!blink_i) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + CW'(1);
    end
  end

  assign w_vis   = !(blink_i && r_blink_phase);
  assign w_d3_nz = (r_digit3 != 4'd0);
  assign w_d2_nz = w_d3_nz || (r_digit2 != 4'd0);
  assign w_d1_nz = w_d2_nz || (r_digit1 != 4'd0);

  assign val_if.value_ready_o = r_ready;
  assign digit0_o    = r_digit0;
  assign digit1_o    = r_digit1;
  assign digit2_o    = r_digit2;
  assign digit3_o    = r_digit3;
  assign overflow_o  = r_overflow;
  assign digit0_en_o = w_vis;
  assign digit1_en_o = w_vis && (!blank_lz_i || w_d1_nz);
  assign digit2_en_o = w_vis && (!blank_lz_i || w_d2_nz);
  assign digit3_en_o = w_vis && (!blank_lz_i || w_d3_nz);

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - self-checking bench for score_display_ctrl
module tb_score_display_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       blank_lz;
  logic       blink;
  logic       d0_en, d1_en, d2_en, d3_en;
  logic [3:0] d0, d1, d2, d3;
  logic       ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int cur_v    = 0;

  always #5 clk = ~clk;

  score_display_ctrl_if vif ();

  score_display_ctrl #(.BLINK_HALF(4)) dut (
    .clk_1k_i    (clk),
    .rst_i       (rst),
    .val_if      (vif.slave),
    .blank_lz_i  (blank_lz),
    .blink_i     (blink),
    .digit0_en_o (d0_en),
    .digit0_o    (d0),
    .digit1_en_o (d1_en),
    .digit1_o    (d1),
    .digit2_en_o (d2_en),
    .digit2_o    (d2),
    .digit3_en_o (d3_en),
    .digit3_o    (d3),
    .overflow_o  (ovf)
  );

  // Decimal digit k of the displayed value, saturating at 9999.
  function automatic int mdig(input int v, input int k);
    int s;
    s = (v > 9999) ? 9999 : v;
    return (s / (10 ** k)) % 10;
  endfunction

  // Digit k is lit when visible and either blanking is off, it is the ones
  // digit, or the number has at least k+1 significant digits.
  function automatic int men(input int v, input int k, input bit blz, input bit vis);
    int s;
    s = (v > 9999) ? 9999 : v;
    return (vis && (k == 0 || !blz || s >= 10 ** k)) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_display(input string tag);
    chk({tag, " d0"}, 32'(d0), mdig(cur_v, 0));
    chk({tag, " d1"}, 32'(d1), mdig(cur_v, 1));
    chk({tag, " d2"}, 32'(d2), mdig(cur_v, 2));
    chk({tag, " d3"}, 32'(d3), mdig(cur_v, 3));
    chk({tag, " en0"}, 32'(d0_en), men(cur_v, 0, blank_lz, 1'b1));
    chk({tag, " en1"}, 32'(d1_en), men(cur_v, 1, blank_lz, 1'b1));
    chk({tag, " en2"}, 32'(d2_en), men(cur_v, 2, blank_lz, 1'b1));
    chk({tag, " en3"}, 32'(d3_en), men(cur_v, 3, blank_lz, 1'b1));
    chk({tag, " ovf"}, 32'(ovf), (cur_v > 9999) ? 1 : 0);
  endtask

  // Called at a negedge with ready high. Offers v before edge N, optionally
  // pulses a competing value mid-conversion, and checks the N+15 latency.
  task automatic convert(input string tag, input int v, input bit glitch);
    vif.value_valid_i = 1'b1;
    vif.value_i       = 14'(v);
    @(negedge clk);
    vif.value_valid_i = 1'b0;
    vif.value_i       = '0;
    chk({tag, " ready_low_after_accept"}, 32'(vif.value_ready_o), 0);
    for (int i = 1; i <= 14; i++) begin
      if (glitch && i == 5) begin
        vif.value_valid_i = 1'b1;
        vif.value_i       = 14'd555;
      end
      @(negedge clk);
      vif.value_valid_i = 1'b0;
      vif.value_i       = '0;
      if (vif.value_ready_o !== 1'b0 || i == 14) begin
        chk({tag, " ready_low_conv"}, 32'(vif.value_ready_o), 0);
      end
      if (i == 14) begin
        chk({tag, " old_d0_held"}, 32'(d0), mdig(cur_v, 0));
        chk({tag, " old_d3_held"}, 32'(d3), mdig(cur_v, 3));
      end
    end
    @(negedge clk);
    cur_v = v;
    chk({tag, " ready_high_after_load"}, 32'(vif.value_ready_o), 1);
    check_display(tag);
  endtask

  initial begin
    int v;
    rst               = 1'b1;
    blank_lz          = 1'b0;
    blink             = 1'b0;
    vif.value_valid_i = 1'b0;
    vif.value_i       = '0;
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(vif.value_ready_o), 1);
    check_display("reset_noblank");
    blank_lz = 1'b1;
    #1;
    check_display("reset_blank");
    @(negedge clk);
    rst      = 1'b0;
    blank_lz = 1'b0;
    @(negedge clk);

    convert("v1234", 1234, 1'b0);
    blank_lz = 1'b1;
    convert("v7", 7, 1'b0);
    convert("v1005", 1005, 1'b0);
    convert("v12000", 12000, 1'b0);
    convert("v42", 42, 1'b0);
    blank_lz = 1'b0;
    convert("glitch1234", 1234, 1'b1);
    convert("v9999", 9999, 1'b0);
    convert("v10000", 10000, 1'b0);
    convert("v0", 0, 1'b0);
    convert("v1234b", 1234, 1'b0);

    // Reset in the middle of a conversion.
    vif.value_valid_i = 1'b1;
    vif.value_i       = 14'd777;
    @(negedge clk);
    vif.value_valid_i = 1'b0;
    vif.value_i       = '0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cur_v = 0;
    chk("midconv_rst ready", 32'(vif.value_ready_o), 1);
    check_display("midconv_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("after_rst ready", 32'(vif.value_ready_o), 1);
    check_display("after_rst_no_load");

    // Randomized values and blanking.
    for (int k = 0; k < 10; k++) begin
      v        = int'($urandom_range(0, 16383));
      if (k % 3 == 0) v = int'($urandom_range(0, 120));
      blank_lz = 1'($urandom_range(0, 1));
      convert($sformatf("rand%0d_%0d", k, v), v, 1'b0);
    end

    // Blink with BLINK_HALF=4: on 4 cycles, off 4 cycles.
    blank_lz = 1'b0;
    convert("pre_blink", 8888, 1'b0);
    blink = 1'b1;
    #1;
    for (int t = 0; t < 16; t++) begin
      chk($sformatf("blink t%0d en0", t), 32'(d0_en), ((t / 4) % 2 == 0) ? 1 : 0);
      chk($sformatf("blink t%0d en3", t), 32'(d3_en), ((t / 4) % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("blink off_phase en0", 32'(d0_en), 0);
    blink = 1'b0;
    #1;
    chk("blink drop en0", 32'(d0_en), 1);
    @(negedge clk);
    chk("blink drop next en0", 32'(d0_en), 1);
    chk("blink drop next en2", 32'(d2_en), 1);
    blink = 1'b1;
    #1;
    for (int t = 0; t < 8; t++) begin
      chk($sformatf("reblink t%0d en1", t), 32'(d1_en), ((t / 4) % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end
    blink = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
